// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux-select arbiter.
package mux_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Priority pointer after releasing input sel: the requester just past it,
    // wrapping to 0 after the last input (N need not be a power of 2).
    function automatic int next_ptr(input int sel, input int n);
        return (sel == n - 1) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request / grant / select bundle between requesters, arbiter and downstream mux.
interface mux_rr_arbiter_if #(
    parameter int N = 2
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]     req;
    logic             out_ready;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             out_valid;

    // Arbiter side: sees requests and downstream ready, drives grant and select.
    modport master (
        input  req,
        input  out_ready,
        output gnt,
        output sel,
        output out_valid
    );

    // Environment side: requesters plus downstream consumer.
    modport slave (
        output req,
        output out_ready,
        input  gnt,
        input  sel,
        input  out_valid
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr.
module rr_pick #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    // Scan ptr, ptr+1, ..., wrapping at N; the first requester seen wins.
    always_comb begin : search
        int               pos;
        logic [SEL_W-1:0] pos_idx;
        any     = 1'b0;
        idx     = '0;
        onehot  = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = SEL_W'(pos);
            if (!any && req[pos_idx]) begin
                any = 1'b1;
                idx = pos_idx;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a N:1 mux select, with per-grant burst limit
// and a valid/ready hold so sel never changes under backpressure.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int BURST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.master  bus
);

    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    arb_state_t       state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx;
    logic [SEL_W-1:0] sel_q, sel_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [N-1:0]     gnt_q, gnt_nx;
    logic             valid_q, valid_nx;

    logic             xfer;
    logic             rel;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N-1:0]     pick_onehot;

    // A release happens on the last beat of a burst or when the owner has
    // stopped requesting; the picker then already uses the rotated pointer so
    // the next grant lands on the same edge with no bubble.
    assign xfer     = valid_q & bus.out_ready;
    assign rel      = xfer & ((cnt == CNT_LAST) | ~bus.req[sel_q]);
    assign pick_ptr = rel ? SEL_W'(next_ptr(int'(sel_q), N)) : ptr;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // State and registered outputs; reset clears immediately, mid-burst too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            gnt_q   <= gnt_nx;
            sel_q   <= sel_nx;
            valid_q <= valid_nx;
        end
    end

    // Next state: leave idle on any request, return only when a release finds no one.
    always_comb begin
        state_nx = state;
        unique case (state)
            ARB_IDLE:  state_nx = pick_any ? ARB_GRANT : ARB_IDLE;
            ARB_GRANT: state_nx = (rel && !pick_any) ? ARB_IDLE : ARB_GRANT;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    // Next outputs, pointer and burst count; everything holds unless a grant
    // is issued, a beat is transferred, or the owner is released.
    always_comb begin
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        gnt_nx   = gnt_q;
        sel_nx   = sel_q;
        valid_nx = valid_q;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_nx   = pick_onehot;
                    sel_nx   = pick_idx;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                end
            end
            ARB_GRANT: begin
                if (rel) begin
                    ptr_nx = pick_ptr;
                    cnt_nx = '0;
                    if (pick_any) begin
                        gnt_nx   = pick_onehot;
                        sel_nx   = pick_idx;
                        valid_nx = 1'b1;
                    end else begin
                        gnt_nx   = '0;
                        valid_nx = 1'b0;
                    end
                end else if (xfer) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                gnt_nx   = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: two arbiter instances (N=3/BURST=1 and N=2/BURST=3) share
// clock and reset; a driver applies stimulus at the falling edge and queues the
// reference model's prediction, a monitor compares after each rising edge.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.N(3)) bus_a ();
    mux_rr_arbiter_if #(.N(2)) bus_b ();

    mux_rr_arbiter #(.N(3), .BURST(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    mux_rr_arbiter #(.N(2), .BURST(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gnt;
        int         sel;
        bit         vld;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model per instance: owner index (-1 when idle), pointer, beats used.
    int m_own[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_sel[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [2:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int j = (p + k) % n;
            if (r[2'(j)]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1;
            m_ptr[i] = 0;
            m_cnt[i] = 0;
            m_sel[i] = 0;
        end
    endfunction

    function automatic void model_step(input int i, input int n, input int burst,
                                       input logic [2:0] r, input bit rdy);
        int w;
        if (m_own[i] < 0) begin
            w = pick(r, m_ptr[i], n);
            if (w >= 0) begin
                m_own[i] = w;
                m_sel[i] = w;
                m_cnt[i] = 0;
            end
        end else if (rdy) begin
            if (m_cnt[i] == burst - 1 || !r[2'(m_own[i])]) begin
                m_ptr[i] = (m_own[i] + 1) % n;
                w = pick(r, m_ptr[i], n);
                m_cnt[i] = 0;
                if (w >= 0) begin
                    m_own[i] = w;
                    m_sel[i] = w;
                end else begin
                    m_own[i] = -1;
                end
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t e;
        e.gnt = (m_own[i] >= 0) ? 3'(1 << m_own[i]) : 3'b000;
        e.sel = m_sel[i];
        e.vld = (m_own[i] >= 0);
        return e;
    endfunction

    // One clock of stimulus, applied at the falling edge.
    task automatic cycle(input logic rstv, input logic [2:0] ra, input bit ya,
                         input logic [1:0] rb, input bit yb);
        logic was;
        @(negedge clk);
        was             = rst_n;
        rst_n           = rstv;
        bus_a.req       = ra;
        bus_a.out_ready = ya;
        bus_b.req       = rb;
        bus_b.out_ready = yb;
        if (!rstv && was) begin
            #1;
            check("async_clr_a_gnt", 32'(bus_a.gnt), 32'd0);
            check("async_clr_a_sel", 32'(bus_a.sel), 32'd0);
            check("async_clr_a_vld", 32'(bus_a.out_valid), 32'd0);
            check("async_clr_b_gnt", 32'(bus_b.gnt), 32'd0);
            check("async_clr_b_sel", 32'(bus_b.sel), 32'd0);
            check("async_clr_b_vld", 32'(bus_b.out_valid), 32'd0);
        end
        if (!rstv) begin
            model_reset();
        end else begin
            model_step(0, 3, 1, ra, ya);
            model_step(1, 2, 3, {1'b0, rb}, yb);
        end
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
    endtask

    // Monitor: compare the registered outputs just after each rising edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_gnt", 32'(bus_a.gnt), 32'(e.gnt));
                check("a_sel", 32'(bus_a.sel), 32'(e.sel));
                check("a_vld", 32'(bus_a.out_valid), 32'(e.vld));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_gnt", 32'(bus_b.gnt), 32'(e.gnt));
                check("b_sel", 32'(bus_b.sel), 32'(e.sel));
                check("b_vld", 32'(bus_b.out_valid), 32'(e.vld));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus_a.req       = 3'b101;
        bus_a.out_ready = 1'b0;
        bus_b.req       = 2'b11;
        bus_b.out_ready = 1'b0;
        model_reset();

        // Requests present during reset must not be granted.
        repeat (3) cycle(1'b0, 3'b101, 1'b1, 2'b11, 1'b1);

        // Rotation with wrap (A skips input 1) and bursts of three (B).
        repeat (10) cycle(1'b1, 3'b101, 1'b1, 2'b11, 1'b1);

        // Lone requester on A; early release on B by dropping its owner.
        repeat (6) cycle(1'b1, 3'b010, 1'b1, 2'b11, 1'b1);
        cycle(1'b1, 3'b010, 1'b1, 2'b10, 1'b1);
        cycle(1'b1, 3'b010, 1'b1, 2'b01, 1'b1);

        // Backpressure: owner drops its request while stalled, grant must hold.
        cycle(1'b1, 3'b110, 1'b0, 2'b10, 1'b0);
        cycle(1'b1, 3'b110, 1'b0, 2'b10, 1'b0);
        cycle(1'b1, 3'b000, 1'b0, 2'b00, 1'b0);
        cycle(1'b1, 3'b000, 1'b0, 2'b00, 1'b0);
        cycle(1'b1, 3'b000, 1'b0, 2'b01, 1'b0);
        cycle(1'b1, 3'b001, 1'b1, 2'b01, 1'b1);
        cycle(1'b1, 3'b000, 1'b1, 2'b00, 1'b1);
        cycle(1'b1, 3'b000, 1'b1, 2'b00, 1'b1);

        // Reset dropped mid-burst, then arbitration restarts from pointer 0.
        repeat (2) cycle(1'b1, 3'b111, 1'b1, 2'b11, 1'b1);
        cycle(1'b0, 3'b111, 1'b1, 2'b11, 1'b1);
        repeat (6) cycle(1'b1, 3'b111, 1'b1, 2'b11, 1'b1);

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 1500; it++) begin
            logic [2:0] ra;
            logic [1:0] rb;
            bit         ya;
            bit         yb;
            ra = 3'($urandom_range(0, 7));
            rb = 2'($urandom_range(0, 3));
            ya = ($urandom_range(0, 9) < 7);
            yb = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 199) == 0) begin
                cycle(1'b0, ra, ya, rb, yb);
                if ($urandom_range(0, 1) == 1) cycle(1'b0, ra, ya, rb, yb);
            end else begin
                cycle(1'b1, ra, ya, rb, yb);
            end
        end

        @(posedge clk);
        #2;
        check("queue_drain", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the MUX2_1 / N:1 mux family and drives the mux `sel` input.
- Arbitrates N request lines and holds the selection stable under a valid/ready handshake with the downstream consumer.
- Allows up to BURST transfers per grant before rotating priority.
- Fully registered outputs, so the mux select never glitches.

Parameters:
- N, 2, number of requesters / mux data inputs (N >= 2, need not be a power of 2).
- BURST, 1, maximum transfers per grant before priority rotates (BURST >= 1).
- SEL_W, $clog2(N), select width; derived, must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request per input; bit i asks for mux input i.
- out_ready  input  1  downstream accepts the current beat.
- gnt  output  N  one-hot grant; all zero when idle.
- sel  output  SEL_W  binary index of granted input; drives mux sel.
- out_valid  output  1  the mux output currently carries a granted beat.

Behaviour:
- Reset (async, rst_n=0) clears everything immediately, independent of clk:
  - state=ARB_IDLE, gnt=0, sel=0, out_valid=0.
  - Priority pointer ptr=0; burst counter cnt=0.
  - A reset asserted mid-burst discards the burst.
- Winner search: circular order ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first asserted req wins.
- ARB_IDLE:
  - If any req is set, the next edge enters ARB_GRANT with gnt=onehot(winner), sel=winner, out_valid=1, cnt=0.
  - Latency from req to out_valid is 1 cycle.
  - With no req, stay idle; sel holds its last value.
- Transfer: a transfer occurs in any cycle where out_valid and out_ready are both 1.
- ARB_GRANT, no transfer: gnt, sel and out_valid are held unchanged. Deassertion of req[sel] is ignored until a transfer occurs.
- ARB_GRANT, transfer that is not a release: cnt increments and the grant is held.
- ARB_GRANT, release: a release is a transfer where cnt==BURST-1, or where req[sel]==0 in the transfer cycle. On release:
  - ptr <= (sel==N-1) ? 0 : sel+1.
  - Re-arbitrate in the same cycle using the new pointer order, with no bubble.
  - If there is a winner, stay in ARB_GRANT with the new gnt/sel and cnt=0. The released requester has lowest priority but may win again if it is the only one requesting.
  - If there is no winner, go to ARB_IDLE: gnt=0, out_valid=0, sel holds.
- Invariants:
  - sel is stable whenever out_valid=1 and out_ready=0.
  - gnt is always one-hot or zero, and gnt[sel]=1 whenever out_valid=1.
- Width rule: cnt is $clog2(BURST+1) bits wide and never exceeds BURST-1.
- BURST=1 degenerates to strict per-beat rotation.
- Simultaneous events:
  - A req change in the release cycle is honoured by that cycle's re-arbitration.
  - req=0 with out_ready=1 while idle leaves the block idle.

Decomposition:
- Shared package mux_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
  - Function next_ptr(sel, N) implementing the wrap rule.
- One sub-module: rr_pick, a combinational rotating-priority picker.
  - Inputs: req, ptr.
  - Outputs: any, idx, onehot.
  - Instantiated once in mux_rr_arbiter.

Test Plan:
- Reset: N=2, req=2'b11 while rst_n=0 -> gnt=00, sel=0, out_valid=0. First edge after rst_n=1 -> gnt=01, sel=0, out_valid=1.
- Rotation: N=2, BURST=1, req=11, out_ready=1 constant -> sel sequence 0,1,0,1,... each cycle, out_valid stays 1 with no bubble.
- Backpressure: grant on sel=1, out_ready=0 for 5 cycles, req[1] dropped in cycle 2 -> gnt=10, sel=1 held all 5 cycles. out_ready=1 -> one transfer, then the grant moves to input 0 (if requesting) or the block goes idle.
- Burst: N=2, BURST=3, req=11, out_ready=1 -> sel 0,0,0,1,1,1,0. Early release: drop req[0] during beat 2 -> sel 0,0,1.
- Wrap, N=3: BURST=1, req=101, out_ready=1 -> sel 0,2,0,2 (index 1 skipped). Lone requester req=010 -> sel=1 re-granted every cycle, out_valid continuous.
- Async reset mid-burst: drop rst_n between edges during BURST=3 beat 2 -> gnt/out_valid clear before the next edge. After release, arbitration restarts from ptr=0.
